seg_scan_ctrl: RTL and testbench
================================

# seg_scan_ctrl

Memory-mapped seven-segment display controller that sits directly downstream of the hCPU data bus and drives the board's digit-select and segment pins. It decodes CPU stores (`writeM`/`addressM`/`outM`) into a small register bank and provides combinational readback for `inM`. It runs a blanked, tear-free multiplexed scan of up to 8 hex digits, using `segcom` for nibble-to-segment decode.

## Interface
Parameters:
- `DIGITS`, 4: number of scanned digits, 1..8.
- `SCAN_DIV`, 256: clock cycles per digit slot, ≥ 2.
- `BLANK_CYCLES`, 16: cycles of each slot spent blanked, 1..`SCAN_DIV`-1.
- `BASE_ADDR`, 16'h4000: word address of register 0.

Ports:
- `clock`  in  1  system clock; single clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `writeM`  in  1  CPU store strobe.
- `addressM`  in  16  CPU data address.
- `outM`  in  16  CPU store data.
- `rdata`  out  16  register readback, for `inM`; combinational.
- `hit`  out  1  `addressM` is in `BASE_ADDR`..`BASE_ADDR`+2; combinational.
- `sel`  out  8  digit select, active-low; bit i selects digit i.
- `data`  out  8  segment pattern, active-low; bit 7 is the decimal point.

## Operation
- Registers:
  - `VAL_LO` at +0 holds digits 3..0, one nibble per digit, digit 0 = bits 3:0.
  - `VAL_HI` at +1 holds digits 7..4.
  - `CTRL` at +2: bit 0 = enable, bits 15:8 = dp mask (bit 8+i lights the dp of digit i).
  - `CTRL` bits 7:1 read as 0.
- Write: when `writeM`=1 and `hit`=1, the addressed register takes `outM` at the clock edge. Writes to other addresses are ignored.
- Readback: `rdata` is the live register selected by `addressM[1:0]`; `rdata` = 0 when `hit`=0 or the offset is 3.
- Shadow: a shadow copy of `VAL_LO`, `VAL_HI` and the dp mask drives the pins. The shadow loads from the live registers only at frame wrap, so a frame never mixes old and new values.
- Scan FSM states:
  - BLANK: `sel`=8'hFF and `data`=8'hFF for `BLANK_CYCLES` cycles, then go to DRIVE.
  - DRIVE: `sel` = one-hot-low on `digit`, `data` = `segcom`(nibble[`digit`]) with bit 7 = ~dp[`digit`], for `SCAN_DIV`-`BLANK_CYCLES` cycles.
  - DRIVE then returns to BLANK with `digit` ← (`digit`+1) mod `DIGITS`.
- Frame wrap is the DRIVE→BLANK transition where `digit` goes `DIGITS`-1 → 0. The shadow loads on that same edge.
- `sel` bits ≥ `DIGITS` are constant 1.
- Enable = 0:
  - FSM is held in BLANK with `digit`=0 and the slot counter at 0.
  - The shadow loads every cycle.
  - Pins stay blank.
  - On enable 0→1, scanning starts with a full BLANK slot at digit 0.
- Arithmetic: slot counter is ceil(log2(`SCAN_DIV`)) bits and returns to 0 at each state change. `digit` is 3 bits, wraps at `DIGITS` (not at 8).

## Timing
- Reset values:
  - `VAL_LO` = `VAL_HI` = 0, `CTRL` = 16'h0001, shadow = 0.
  - FSM in BLANK, `digit`=0, counter=0.
  - `sel`=8'hFF, `data`=8'hFF.
- Reset asserted mid-frame returns all of the above on the next edge. A write in the same cycle as reset is dropped.
- `sel`/`data` are registered and change one cycle after the FSM state change they reflect.
- Frame period = `DIGITS`×`SCAN_DIV` cycles. Digit-on duty = (`SCAN_DIV`-`BLANK_CYCLES`)/`SCAN_DIV`.
- Write latency:
  - `rdata` reflects a write from the cycle after the write edge.
  - Pins reflect it from the first DRIVE of digit 0 after the next frame wrap. Worst case is ≈ one frame plus `BLANK_CYCLES`+1.
- Write coinciding with the frame-wrap edge: the shadow captures the pre-write value, and the new value appears one frame later.
- Back-to-back writes within a frame: only the last one is displayed.

## Configuration
- `SEG_LZ_SUPPRESS_EN` defined:
  - Leading-zero blanking. Any digit above the most significant nonzero nibble of the shadow value (digit 0 excluded) shows `data`=8'hFF during its DRIVE slot, unless its dp bit is set. In that case `data`=8'h7F.
  - `sel` still scans normally.
  - Suppression is evaluated from the shadow, so it is also frame-stable.
- Not defined: all `DIGITS` digits always show their hex value.

## Test plan
- Reset, then `DIGITS`=4, `SCAN_DIV`=8, `BLANK_CYCLES`=2, `VAL_LO` written to 16'h1234 → each frame drives 4 then 3 then 2 then 1 with `sel` FE,FD,FB,F7. Each digit is preceded by 2 cycles of `sel`=FF, and the frame is 32 cycles.
- Write 16'hABCD to `VAL_LO` mid-frame → `rdata`=ABCD on the next cycle. Pins keep showing the old value until the wrap, then D,C,B,A.
- Write `CTRL`=16'h0500 (enable=0, dp on digits 0 and 2) → `sel`/`data` stay FF. Then write 16'h0501 → scan restarts at digit 0 with `data[7]`=0 on digits 0 and 2 only.
- Write exactly on the wrap edge → the frame after the wrap still shows the old value, and the following frame shows the new one.
- Assert `reset` during a DRIVE slot → `sel`=FF, `data`=FF, `VAL_LO`=0, `CTRL`=0001 on the next edge. Then digit 0 shows 0 after the BLANK slot.
- With `SEG_LZ_SUPPRESS_EN` defined, `VAL_LO`=16'h0042 → digits 3 and 2 are blank (`data`=FF), digits 1 and 0 show 4 and 2. `VAL_LO`=0 → only digit 0 shows 0.

Source files
------------

// File: rtl/seg_scan_ctrl.sv
// Memory-mapped multiplexed seven-segment scan controller.
// Define SEG_LZ_SUPPRESS_EN to enable leading-zero blanking.
module seg_scan_ctrl #(
  parameter int          DIGITS       = 4,
  parameter int          SCAN_DIV     = 256,
  parameter int          BLANK_CYCLES = 16,
  parameter logic [15:0] BASE_ADDR    = 16'h4000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        writeM,
  input  logic [15:0] addressM,
  input  logic [15:0] outM,
  output logic [15:0] rdata,
  output logic        hit,
  output logic [7:0]  sel,
  output logic [7:0]  data
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam logic [CW-1:0] BLANK_LAST =
    CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] DRIVE_LAST =
    CW'(SCAN_DIV - BLANK_CYCLES - 1);
  localparam logic [2:0] DIG_LAST = 3'(DIGITS - 1);

  localparam logic [0:0] ST_BLANK = 1'b0;
  localparam logic [0:0] ST_DRIVE = 1'b1;

  logic [15:0]   val_lo, val_hi;
  logic          en;
  logic [7:0]    dp_mask;
  logic [31:0]   sh_val;
  logic [7:0]    sh_dp;
  logic [0:0]    state;
  logic [CW-1:0] cnt;
  logic [2:0]    digit;

  logic [15:0] off;
  logic        wr;
  logic [31:0] shifted;
  logic [3:0]  nib;
  logic        dp_n;
  logic [7:0]  sel_d, data_d;

  function automatic logic [6:0] segcom(
    input logic [3:0] n
  );
    case (n)
      4'h0: segcom = 7'h40;
      4'h1: segcom = 7'h79;
      4'h2: segcom = 7'h24;
      4'h3: segcom = 7'h30;
      4'h4: segcom = 7'h19;
      4'h5: segcom = 7'h12;
      4'h6: segcom = 7'h02;
      4'h7: segcom = 7'h78;
      4'h8: segcom = 7'h00;
      4'h9: segcom = 7'h10;
      4'hA: segcom = 7'h08;
      4'hB: segcom = 7'h03;
      4'hC: segcom = 7'h46;
      4'hD: segcom = 7'h21;
      4'hE: segcom = 7'h06;
      default: segcom = 7'h0E;
    endcase
  endfunction

  // Wrapping subtraction makes the range test a single compare.
  assign off = addressM - BASE_ADDR;
  assign hit = off < 16'd3;
  assign wr  = writeM & hit;

  always_comb begin
    rdata = '0;
    unique case (1'b1)
      hit && off[1:0] == 2'd0: rdata = val_lo;
      hit && off[1:0] == 2'd1: rdata = val_hi;
      hit && off[1:0] == 2'd2:
        rdata = {dp_mask, 7'b0, en};
      default: rdata = '0;
    endcase
  end

  assign shifted = sh_val >> {digit, 2'b00};
  assign nib     = shifted[3:0];
  assign dp_n    = ~sh_dp[digit];

  always_comb begin
    sel_d  = 8'hFF;
    data_d = 8'hFF;
    if (state == ST_DRIVE) begin
      sel_d  = ~(8'h01 << digit);
      data_d = {dp_n, segcom(nib)};
`ifdef SEG_LZ_SUPPRESS_EN
      if (digit != 3'd0 && shifted == 32'd0)
        data_d = {dp_n, 7'h7F};
`endif
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      val_lo  <= '0;
      val_hi  <= '0;
      en      <= 1'b1;
      dp_mask <= '0;
      sh_val  <= '0;
      sh_dp   <= '0;
      state   <= ST_BLANK;
      cnt     <= '0;
      digit   <= '0;
      sel     <= 8'hFF;
      data    <= 8'hFF;
    end else begin
      if (wr) begin
        case (off[1:0])
          2'd0: val_lo <= outM;
          2'd1: val_hi <= outM;
          2'd2: begin
            en      <= outM[0];
            dp_mask <= outM[15:8];
          end
          default: ;
        endcase
      end
      sel  <= sel_d;
      data <= data_d;
      if (!en) begin
        state  <= ST_BLANK;
        cnt    <= '0;
        digit  <= '0;
        sh_val <= {val_hi, val_lo};
        sh_dp  <= dp_mask;
      end else if (state == ST_BLANK) begin
        if (cnt == BLANK_LAST) begin
          state <= ST_DRIVE;
          cnt   <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else if (cnt == DRIVE_LAST) begin
        state <= ST_BLANK;
        cnt   <= '0;
        // Frame wrap: latch the pre-write live values.
        if (digit == DIG_LAST) begin
          digit  <= '0;
          sh_val <= {val_hi, val_lo};
          sh_dp  <= dp_mask;
        end else begin
          digit <= digit + 1'b1;
        end
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl with a time-based
// reference model of the scan and register bank.
module tb_seg_scan_ctrl;

  localparam int D     = 4;
  localparam int S     = 8;
  localparam int B     = 2;
  localparam int FRAME = D * S;
  localparam logic [15:0] BA = 16'h4000;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        writeM = 1'b0;
  logic [15:0] addressM = 16'h0;
  logic [15:0] outM = 16'h0;
  logic [15:0] rdata;
  logic        hit;
  logic [7:0]  sel;
  logic [7:0]  data;

  seg_scan_ctrl #(
    .DIGITS(D), .SCAN_DIV(S),
    .BLANK_CYCLES(B), .BASE_ADDR(BA)
  ) dut (
    .clock(clock), .reset(reset),
    .writeM(writeM), .addressM(addressM),
    .outM(outM), .rdata(rdata), .hit(hit),
    .sel(sel), .data(data)
  );

  always #5 clock = ~clock;

  logic [6:0] seg_tab [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30,
    7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03,
    7'h46, 7'h21, 7'h06, 7'h0E
  };

  logic [15:0] m_lo, m_hi;
  logic        m_en;
  logic [7:0]  m_dp;
  logic [31:0] s_val;
  logic [7:0]  s_dp;
  int          t;
  logic        started = 1'b0;
  logic [15:0] exp_q [$];

  int n_chk = 0;
  int n_pass = 0;

  function automatic logic [15:0] pins(
    input int tt, input logic [31:0] sv,
    input logic [7:0] sdp
  );
    int pos, d;
    logic [3:0] n;
    logic [7:0] sl, dt;
    pos = tt % S;
    d   = (tt / S) % D;
    if (pos < B) return 16'hFFFF;
    n  = 4'((sv >> (4 * d)) & 32'hF);
    sl = ~(8'(1) << d);
    dt = {~sdp[d], seg_tab[n]};
`ifdef SEG_LZ_SUPPRESS_EN
    if (d != 0 && (sv >> (4 * d)) == 0)
      dt = {~sdp[d], 7'h7F};
`endif
    return {sl, dt};
  endfunction

  function automatic logic m_hit(input logic [15:0] a);
    return a >= BA && a <= BA + 16'd2;
  endfunction

  function automatic logic [15:0] m_rd(
    input logic [15:0] a
  );
    if (!m_hit(a)) return 16'h0;
    case (a - BA)
      16'd0: return m_lo;
      16'd1: return m_hi;
      default: return {m_dp, 7'b0, m_en};
    endcase
  endfunction

  always @(posedge clock) begin
    started = 1'b1;
    if (reset) begin
      exp_q.push_back(16'hFFFF);
      m_lo = 0; m_hi = 0; m_en = 1; m_dp = 0;
      s_val = 0; s_dp = 0; t = 0;
    end else begin
      exp_q.push_back(pins(t, s_val, s_dp));
      if (!m_en) begin
        s_val = {m_hi, m_lo}; s_dp = m_dp; t = 0;
      end else begin
        t = (t + 1) % FRAME;
        if (t == 0) begin
          s_val = {m_hi, m_lo}; s_dp = m_dp;
        end
      end
      if (writeM && m_hit(addressM)) begin
        case (addressM - BA)
          16'd0: m_lo = outM;
          16'd1: m_hi = outM;
          default: begin
            m_en = outM[0]; m_dp = outM[15:8];
          end
        endcase
      end
    end
  end

  always @(negedge clock) begin
    logic [15:0] e;
    if (started) begin
      n_chk++;
      if (exp_q.size() == 0) begin
        $display("FAIL pins: no expected entry");
      end else begin
        e = exp_q.pop_front();
        if ({sel, data} === e) n_pass++;
        else $display("FAIL pins t=%0t: got %h/%h want %h/%h",
                      $time, sel, data, e[15:8], e[7:0]);
      end
      n_chk++;
      if (hit === m_hit(addressM)) n_pass++;
      else $display("FAIL hit a=%h: got %b want %b",
                    addressM, hit, m_hit(addressM));
      n_chk++;
      if (rdata === m_rd(addressM)) n_pass++;
      else $display("FAIL rdata a=%h: got %h want %h",
                    addressM, rdata, m_rd(addressM));
    end
  end

  task automatic cyc(
    input logic w, input logic [15:0] a,
    input logic [15:0] d, input logic r
  );
    reset = r; writeM = w; addressM = a; outM = d;
    @(posedge clock);
    #1;
  endtask

  function automatic logic [15:0] rnd_addr();
    case ($urandom_range(0, 5))
      0: return BA;
      1: return BA + 16'd1;
      2: return BA + 16'd2;
      3: return BA + 16'd3;
      4: return BA - 16'd1;
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      cyc(1'b0, rnd_addr(), 16'($urandom), 1'b0);
  endtask

  task automatic wait_t(input int want, input string nm);
    int k;
    for (k = 0; k < 2 * FRAME; k++) begin
      if (t == want) break;
      cyc(1'b0, rnd_addr(), 16'h0, 1'b0);
    end
    n_chk++;
    if (t == want) n_pass++;
    else $display("FAIL %s: t=%0d want %0d", nm, t, want);
  endtask

  initial begin
    logic [15:0] a, d;
    int r;
    repeat (3) cyc(1'b0, 16'h0, 16'h0, 1'b1);
    cyc(1'b1, BA, 16'h1234, 1'b0);
    idle(3 * FRAME);
    idle(13);
    cyc(1'b1, BA, 16'hABCD, 1'b0);
    idle(2 * FRAME + 5);
    cyc(1'b1, BA + 16'd2, 16'h0500, 1'b0);
    idle(20);
    cyc(1'b1, BA + 16'd2, 16'h0501, 1'b0);
    idle(2 * FRAME + 3);
    wait_t(FRAME - 1, "wrap_wait");
    cyc(1'b1, BA, 16'h5678, 1'b0);
    idle(2 * FRAME + 4);
    wait_t(5, "drive_wait");
    cyc(1'b0, BA, 16'h0, 1'b1);
    cyc(1'b1, BA, 16'h9999, 1'b1);
    idle(FRAME + 4);
    cyc(1'b1, BA, 16'h0042, 1'b0);
    idle(2 * FRAME + 2);
    cyc(1'b1, BA, 16'h0000, 1'b0);
    cyc(1'b1, BA + 16'd1, 16'h0300, 1'b0);
    idle(2 * FRAME + 2);
    cyc(1'b1, BA + 16'd1, 16'h0000, 1'b0);
    idle(2 * FRAME + 2);
    for (int i = 0; i < 4000; i++) begin
      r = $urandom_range(0, 399);
      a = rnd_addr();
      d = 16'($urandom);
      if (a == BA + 16'd2)
        d[0] = ($urandom_range(0, 4) != 0);
      if ($urandom_range(0, 1) == 0) d[7:4] = 4'h0;
      cyc(r < 16, a, d, r == 399);
    end
    idle(2);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
